// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin controller for a shared add/sub/and/or datapath.
// Two valid/ready requesters; registered operands; tagged result held until accepted.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_id,
  output logic             res_carry,
  output logic             res_zero,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_y_q;
  logic             res_id_q, res_carry_q, res_zero_q;
  logic             busy_q;
  logic [CNTW-1:0]  cnt_q;

  logic             idle, gnt, accept, load, hs;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  // On a tie the requester not served last wins.
  assign idle = (state_q == IDLE);
  assign gnt  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  assign req0_ready = idle && !rst && req0_valid && !gnt;
  assign req1_ready = idle && !rst && req1_valid && gnt;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        load    = 1'b1;
        state_d = DONE;
      end
      DONE: if (res_ready) begin
        hs      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract as a + ~b + 1; a clear top bit means a borrow.
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    unique case (op_q)
      2'b00: begin
        alu_y = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
      end
      2'b01: begin
        alu_y = sub_w[WIDTH-1:0];
        alu_c = ~sub_w[WIDTH];
      end
      2'b10: alu_y = a_q & b_q;
      2'b11: alu_y = a_q | b_q;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_id_q    <= 1'b0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        last_q <= gnt;
        id_q   <= gnt;
        a_q    <= gnt ? req1_a  : req0_a;
        b_q    <= gnt ? req1_b  : req0_b;
        op_q   <= gnt ? req1_op : req0_op;
      end
      if (load) begin
        res_valid_q <= 1'b1;
        res_y_q     <= alu_y;
        res_id_q    <= id_q;
        res_carry_q <= alu_c;
        res_zero_q  <= (alu_y == '0);
      end
      if (hs) begin
        res_valid_q <= 1'b0;
        cnt_q       <= cnt_q + 1'b1;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_id    = res_id_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign busy      = busy_q;
  assign ops_done  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, per-cycle model compare, literal pins.
// A second CNTW=2 instance shares the stimulus to exercise counter wrap.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rr;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;

  logic       r0, r1, rv, rid, rc, rz, bz;
  logic [3:0] ry;
  logic [7:0] od;

  logic       r0_2, r1_2, rv_2, rid_2, rc_2, rz_2, bz_2;
  logic [3:0] ry_2;
  logic [1:0] od_2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int g_id[$], g_cyc[$];
  int q_y[$], q_c[$], q_z[$], q_id[$], q_cyc[$];

  int m_age  = -1;
  int m_last = 1;
  int m_cnt  = 0;
  int m_y, m_c, m_z, m_id;

  alu_arbiter #(.WIDTH(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(r0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(r1),
    .res_valid(rv), .res_ready(rr), .res_y(ry), .res_id(rid),
    .res_carry(rc), .res_zero(rz), .busy(bz), .ops_done(od)
  );

  alu_arbiter #(.WIDTH(4), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(r0_2),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(r1_2),
    .res_valid(rv_2), .res_ready(rr), .res_y(ry_2), .res_id(rid_2),
    .res_carry(rc_2), .res_zero(rz_2), .busy(bz_2), .ops_done(od_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_op(int a, int b, int op, int id);
    case (op)
      0: begin m_y = (a + b) % 16; m_c = (a + b >= 16) ? 1 : 0; end
      1: begin m_y = (a - b + 16) % 16; m_c = (a < b) ? 1 : 0; end
      2: begin m_y = a & b; m_c = 0; end
      default: begin m_y = a | b; m_c = 0; end
    endcase
    m_z  = (m_y == 0) ? 1 : 0;
    m_id = id;
  endfunction

  // Model: a free slot accepts, the result shows one edge later and
  // stays until the consumer takes it; ties go to the other requester.
  always @(negedge clk) begin
    int g, e0, e1;
    if (rst) begin
      m_age = -1; m_last = 1; m_cnt = 0;
      chk("rst_r0", r0, 0);  chk("rst_r1", r1, 0);
      chk("rst_rv", rv, 0);  chk("rst_ry", ry, 0);
      chk("rst_id", rid, 0); chk("rst_c", rc, 0);
      chk("rst_z", rz, 0);   chk("rst_busy", bz, 0);
      chk("rst_od", od, 0);  chk("rst_od2", od_2, 0);
    end else begin
      g  = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
      e0 = (m_age < 0 && v0 && g == 0) ? 1 : 0;
      e1 = (m_age < 0 && v1 && g == 1) ? 1 : 0;
      chk("ready0", r0, e0);
      chk("ready1", r1, e1);
      chk("busy", bz, (m_age >= 0) ? 1 : 0);
      chk("res_valid", rv, (m_age >= 1) ? 1 : 0);
      chk("ops_done", od, m_cnt % 256);
      chk("ops_done_w2", od_2, m_cnt % 4);
      if (m_age >= 1) begin
        chk("res_y", ry, m_y);
        chk("res_carry", rc, m_c);
        chk("res_zero", rz, m_z);
        chk("res_id", rid, m_id);
      end
      if (v0 && r0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
      if (v1 && r1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
      if (rv && rr) begin
        q_y.push_back(ry); q_c.push_back(rc); q_z.push_back(rz);
        q_id.push_back(rid); q_cyc.push_back(cyc);
      end
      if (m_age < 0) begin
        if (e0 || e1) begin
          if (g == 0) model_op(a0, b0, op0, 0);
          else        model_op(a1, b1, op1, 1);
          m_last = g;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rr) begin
        m_age = -1;
        m_cnt++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(int who);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who == 0 ? (v0 && r0) : (v1 && r1)) got = 1;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    if (who == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic issue(int who, int a, int b, int op);
    if (who == 0) begin a0 = 4'(a); b0 = 4'(b); op0 = 2'(op); v0 = 1'b1; end
    else          begin a1 = 4'(a); b1 = 4'(b); op1 = 2'(op); v1 = 1'b1; end
    wait_accept(who);
  endtask

  task automatic wait_result();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rv && rr) got = 1;
    end
    chk("result_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_op(int who, int a, int b, int op, int ey, int ec, int ez);
    issue(who, a, b, op);
    wait_result();
    chk("lit_y", q_y[$], ey);
    chk("lit_c", q_c[$], ec);
    chk("lit_z", q_z[$], ez);
    chk("lit_id", q_id[$], who);
    chk("lit_latency", q_cyc[$] - g_cyc[$], 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, acc_cyc;
    rst = 1'b1; v0 = 0; v1 = 0; rr = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    step(2);
    rst = 1'b0; rr = 1'b1;

    do_op(0, 9, 8, 0, 1, 1, 0);
    chk("lit_od_first", od, 1);
    do_op(1, 3, 5, 1, 14, 1, 0);
    do_op(0, 12, 3, 2, 0, 0, 1);
    do_op(1, 5, 10, 3, 15, 0, 0);
    do_op(0, 3, 4, 0, 7, 0, 0);
    do_op(1, 7, 7, 1, 0, 0, 1);
    do_op(0, 15, 15, 0, 14, 1, 0);

    // contention right after reset
    rst = 1'b1; step(2); rst = 1'b0;
    base = g_id.size();
    a0 = 1; b0 = 2; op0 = 0; a1 = 9; b1 = 4; op1 = 1;
    v0 = 1; v1 = 1;
    step(12);
    v0 = 0; v1 = 0;
    step(3);
    chk("lit_grants", g_id.size() - base, 4);
    if (g_id.size() - base >= 4) begin
      chk("lit_g0", g_id[base],     0);
      chk("lit_g1", g_id[base + 1], 1);
      chk("lit_g2", g_id[base + 2], 0);
      chk("lit_g3", g_id[base + 3], 1);
      chk("lit_period", g_cyc[base + 3] - g_cyc[base], 9);
    end
    chk("lit_od_four", od, 4);
    chk("lit_od2_wrap", od_2, 0);

    // backpressure with req1 waiting
    rr = 1'b0;
    issue(0, 6, 6, 0);
    a1 = 2; b1 = 9; op1 = 3; v1 = 1;
    step(7);
    chk("lit_bp_valid", rv, 1);
    chk("lit_bp_y", ry, 12);
    chk("lit_bp_ready1", r1, 0);
    rr = 1'b1;
    acc_cyc = cyc;
    wait_accept(1);
    chk("lit_bp_grant", g_id[$], 1);
    chk("lit_bp_gap", g_cyc[$] - q_cyc[$], 1);
    wait_result();
    chk("lit_bp_res", q_y[$], 11);

    // asynchronous reset during EXEC
    v0 = 1; a0 = 8; b0 = 8; op0 = 0;
    wait_accept(0);
    #1;
    chk("lit_exec_busy", bz, 1);
    v1 = 1;
    rst = 1'b1;
    #1;
    chk("lit_ar_busy", bz, 0);
    chk("lit_ar_rv", rv, 0);
    chk("lit_ar_od", od, 0);
    chk("lit_ar_y", ry, 0);
    chk("lit_ar_ready1", r1, 0);
    step(2);
    rst = 1'b0;
    v0 = 1;
    wait_accept(0);
    chk("lit_ar_tie", g_id[$], 0);
    v1 = 0;
    wait_result();
    chk("lit_ar_od_after", od, 1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
